pipeline_hazard_ctrl: RTL and testbench

Sequencing controller for the five-stage MIPS pipeline, placed beside the ID stage. It detects load-use and branch-operand hazards against the registers decoded in ID, and flushes the wrong-path fetch on taken branches and jumps. It also runs a request/ready handshake with a multi-cycle data memory, freezing the whole pipeline while an access is outstanding. It keeps saturating stall and flush counters for performance checks.

---
 rtl/pipeline_hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Sequencing controller that sits beside the ID stage of a five-stage MIPS
//   pipeline. It does four jobs:
//     - stalls the front end on load-use and branch-operand hazards;
//     - flushes the wrong-path fetch on taken branches and on jumps;
//     - freezes the whole pipeline while a multi-cycle data-memory access is
//       outstanding, releasing it when the memory is ready or on timeout;
//     - keeps saturating performance counters for stall and flush cycles.
//
// Ports
//   clk_i, reset_i                pipeline clock; synchronous active-high reset
//   id_rs_i, id_rt_i              source register fields of the instruction in ID
//   id_uses_rs_i, id_uses_rt_i    the ID instruction really reads rs / rt
//   id_branch_i, id_jump_i        Beq/Bne in ID; Jump in ID
//   id_branch_taken_i             ID branch comparator result
//   ex_reg_write_i, ex_mem_read_i ID/EX RegWrite and MemRead
//   ex_dest_i                     ID/EX destination register
//   mem_mem_read_i, mem_dest_i    EX/MEM MemRead and destination register
//   mem_access_i                  EX/MEM MemRead or MemWrite
//   dmem_ready_i                  data memory access complete
//   pc_write_o .. exmem_write_o   stage register write enables
//   ifid_flush_o                  zero IF/ID
//   idex_bubble_o, memwb_bubble_o load NOP controls into ID/EX, MEM/WB
//   dmem_req_o                    one-cycle access start pulse
//   mem_timeout_o                 sticky flag: a wait ended without ready
//   stall_count_o, flush_count_o  saturating performance counters
//
// States
//   RUN      | normal flow; hazards stall, redirects flush, mem_access issues
//   MEM_WAIT | access outstanding; pipeline frozen until ready or timeout
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  input  logic             id_branch_i,
  input  logic             id_jump_i,
  input  logic             id_branch_taken_i,
  input  logic             ex_reg_write_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_dest_i,
  input  logic             mem_mem_read_i,
  input  logic [4:0]       mem_dest_i,
  input  logic             mem_access_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_write_o,
  output logic             exmem_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             memwb_bubble_o,
  output logic             dmem_req_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] flush_count_o
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  // Wait budget counts down from TIMEOUT; reaching zero means the wait has
  // already spent TIMEOUT cycles, i.e. the elapsed count equals TIMEOUT.
  logic [TW-1:0]    timer_q, timer_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic load_use, br_ex, br_mem, hazard, redirect;
  logic advance;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign ex_rs  = id_uses_rs_i & ex_reg_write_i & (ex_dest_i != 5'd0) & (ex_dest_i == id_rs_i);
  assign ex_rt  = id_uses_rt_i & ex_reg_write_i & (ex_dest_i != 5'd0) & (ex_dest_i == id_rt_i);
  assign mem_rs = id_uses_rs_i & mem_mem_read_i & (mem_dest_i != 5'd0) & (mem_dest_i == id_rs_i);
  assign mem_rt = id_uses_rt_i & mem_mem_read_i & (mem_dest_i != 5'd0) & (mem_dest_i == id_rt_i);

  assign load_use = ex_mem_read_i & (ex_rs | ex_rt);
  assign br_ex    = id_branch_i & (ex_rs | ex_rt);
  assign br_mem   = id_branch_i & (mem_rs | mem_rt);
  assign hazard   = load_use | br_ex | br_mem;
  assign redirect = id_jump_i | (id_branch_i & id_branch_taken_i);

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    timeout_d      = timeout_q;
    advance        = 1'b0;
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    idex_write_o   = 1'b1;
    exmem_write_o  = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    memwb_bubble_o = 1'b0;
    dmem_req_o     = 1'b0;

    if (reset_i) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_write_o   = 1'b0;
      exmem_write_o  = 1'b0;
      idex_bubble_o  = 1'b1;
      memwb_bubble_o = 1'b1;
      state_d        = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          // A new access outranks hazards and redirects: everything freezes.
          if (mem_access_i) begin
            dmem_req_o = 1'b1;
            state_d    = MEM_WAIT;
            timer_d    = TIMER_LOAD;
          end else begin
            advance = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready_i || (timer_q == '0)) begin
            advance = 1'b1;
            state_d = RUN;
            if (!dmem_ready_i) timeout_d = 1'b1;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        default: state_d = RUN;
      endcase

      if (!advance) begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        idex_write_o   = 1'b0;
        exmem_write_o  = 1'b0;
        memwb_bubble_o = 1'b1;
      end else if (hazard) begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
      end else if (redirect) begin
        ifid_flush_o = 1'b1;
      end
    end
  end

  assign stall_cnt_d = (!pc_write_o && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = (ifid_flush_o && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= RUN;
      timer_q     <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_timeout_o = timeout_q;
  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, hand-written
// timeout / reset-during-wait sequences, and a randomized run against a
// cycle-level reference model of the controller's rules.
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  // Output bundle order: {pc, ifid, idex, exmem, flush, idex_bubble, memwb_bubble, req}
  localparam logic [7:0] O_RST = 8'b0000_0110;
  localparam logic [7:0] O_RUN = 8'b1111_0000;
  localparam logic [7:0] O_STL = 8'b0011_0100;
  localparam logic [7:0] O_FLS = 8'b1111_1000;
  localparam logic [7:0] O_ISS = 8'b0000_0011;
  localparam logic [7:0] O_FRZ = 8'b0000_0010;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic             reset_i;
  logic [4:0]       id_rs_i, id_rt_i;
  logic             id_uses_rs_i, id_uses_rt_i, id_branch_i, id_jump_i, id_branch_taken_i;
  logic             ex_reg_write_i, ex_mem_read_i;
  logic [4:0]       ex_dest_i;
  logic             mem_mem_read_i;
  logic [4:0]       mem_dest_i;
  logic             mem_access_i, dmem_ready_i;
  logic             pc_write_o, ifid_write_o, idex_write_o, exmem_write_o;
  logic             ifid_flush_o, idex_bubble_o, memwb_bubble_o, dmem_req_o, mem_timeout_o;
  logic [CNT_W-1:0] stall_count_o, flush_count_o;

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
    .id_branch_i(id_branch_i), .id_jump_i(id_jump_i), .id_branch_taken_i(id_branch_taken_i),
    .ex_reg_write_i(ex_reg_write_i), .ex_mem_read_i(ex_mem_read_i), .ex_dest_i(ex_dest_i),
    .mem_mem_read_i(mem_mem_read_i), .mem_dest_i(mem_dest_i),
    .mem_access_i(mem_access_i), .dmem_ready_i(dmem_ready_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .idex_write_o(idex_write_o), .exmem_write_o(exmem_write_o),
    .ifid_flush_o(ifid_flush_o), .idex_bubble_o(idex_bubble_o),
    .memwb_bubble_o(memwb_bubble_o), .dmem_req_o(dmem_req_o),
    .mem_timeout_o(mem_timeout_o),
    .stall_count_o(stall_count_o), .flush_count_o(flush_count_o)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs, urt, br, jmp, tk, exrw, exmr;
    logic [4:0] exd;
    logic       mmr;
    logic [4:0] md;
    logic       macc, rdy;
  } vec_t;

  typedef struct {
    vec_t       v;
    logic [7:0] out;
    int         stall;
    int         flush;
  } row_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: are we waiting on memory, how many wait cycles
  // have elapsed, and the expected sticky flag and counter values.
  bit m_wait  = 0;
  int m_wcnt  = 0;
  bit m_tmo   = 0;
  int m_stall = 0;
  int m_flush = 0;

  logic [7:0] got_out, exp_out;

  function automatic vec_t mk(bit rst, int rs, int rt, bit urs, bit urt, bit br, bit jmp,
                              bit tk, bit exrw, bit exmr, int exd, bit mmr, int md,
                              bit macc, bit rdy);
    vec_t v;
    v.rst = rst; v.rs = 5'(rs); v.rt = 5'(rt); v.urs = urs; v.urt = urt;
    v.br = br; v.jmp = jmp; v.tk = tk; v.exrw = exrw; v.exmr = exmr;
    v.exd = 5'(exd); v.mmr = mmr; v.md = 5'(md); v.macc = macc; v.rdy = rdy;
    return v;
  endfunction

  function automatic vec_t nop(bit rdy);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endfunction

  // Does a producer (valid, dest) feed a consumer source (use, src)?
  function automatic bit dep(logic use_src, logic valid, logic [4:0] dst, logic [4:0] src);
    return use_src && valid && (dst != 5'd0) && (dst == src);
  endfunction

  function automatic bit model_hazard(vec_t v);
    bit in_ex, in_mem;
    in_ex  = dep(v.urs, v.exrw, v.exd, v.rs) || dep(v.urt, v.exrw, v.exd, v.rt);
    in_mem = dep(v.urs, v.mmr, v.md, v.rs) || dep(v.urt, v.mmr, v.md, v.rt);
    return (v.exmr && in_ex) || (v.br && (in_ex || in_mem));
  endfunction

  function automatic logic [7:0] model_out(vec_t v);
    if (v.rst) return O_RST;
    if (!m_wait) begin
      if (v.macc) return O_ISS;
    end else if (!(v.rdy || m_wcnt == TIMEOUT)) begin
      return O_FRZ;
    end
    if (model_hazard(v)) return O_STL;
    if (v.jmp || (v.br && v.tk)) return O_FLS;
    return O_RUN;
  endfunction

  task automatic model_step(input vec_t v, input logic [7:0] o);
    if (v.rst) begin
      m_wait = 0; m_wcnt = 0; m_tmo = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!o[7] && m_stall < CMAX) m_stall++;
      if (o[3] && m_flush < CMAX) m_flush++;
      if (!m_wait) begin
        if (v.macc) begin m_wait = 1; m_wcnt = 0; end
      end else if (v.rdy || m_wcnt == TIMEOUT) begin
        m_wait = 0;
        if (!v.rdy) m_tmo = 1;
      end else begin
        m_wcnt++;
      end
    end
  endtask

  task automatic drive(input vec_t v);
    reset_i = v.rst; id_rs_i = v.rs; id_rt_i = v.rt;
    id_uses_rs_i = v.urs; id_uses_rt_i = v.urt; id_branch_i = v.br;
    id_jump_i = v.jmp; id_branch_taken_i = v.tk; ex_reg_write_i = v.exrw;
    ex_mem_read_i = v.exmr; ex_dest_i = v.exd; mem_mem_read_i = v.mmr;
    mem_dest_i = v.md; mem_access_i = v.macc; dmem_ready_i = v.rdy;
  endtask

  // Drive one cycle: inputs shortly after the edge, combinational outputs
  // sampled mid-cycle, then wait past the next rising edge.
  task automatic apply(input vec_t v);
    drive(v);
    #2;
    exp_out = model_out(v);
    got_out = {pc_write_o, ifid_write_o, idex_write_o, exmem_write_o,
               ifid_flush_o, idex_bubble_o, memwb_bubble_o, dmem_req_o};
    @(posedge clk_i);
    #1;
    model_step(v, exp_out);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_regs(input string tag, input int stall, input int flush, input bit tmo);
    check({tag, "/stall_count"}, 32'(stall_count_o), stall);
    check({tag, "/flush_count"}, 32'(flush_count_o), flush);
    check({tag, "/mem_timeout"}, 32'(mem_timeout_o), 32'(tmo));
  endtask

  function automatic vec_t rnd(int rdy_bias);
    vec_t v;
    v.rst  = ($urandom_range(0, 63) == 0);
    v.rs   = 5'($urandom_range(0, 3));
    v.rt   = 5'($urandom_range(0, 3));
    v.urs  = ($urandom_range(0, 3) != 0);
    v.urt  = ($urandom_range(0, 1) != 0);
    v.br   = ($urandom_range(0, 3) == 0);
    v.jmp  = ($urandom_range(0, 7) == 0);
    v.tk   = ($urandom_range(0, 1) != 0);
    v.exrw = ($urandom_range(0, 1) != 0);
    v.exmr = ($urandom_range(0, 1) != 0);
    v.exd  = 5'($urandom_range(0, 3));
    v.mmr  = ($urandom_range(0, 1) != 0);
    v.md   = 5'($urandom_range(0, 3));
    v.macc = ($urandom_range(0, 5) == 0);
    v.rdy  = ($urandom_range(0, 7) < rdy_bias);
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t tbl[$];
    vec_t lu;

    drive(nop(0));

    //          rst rs rt urs urt br jmp tk exrw exmr exd mmr md macc rdy
    tbl.push_back('{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_RST, 0, 0});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_RUN, 0, 0});
    tbl.push_back('{mk(0, 5, 0, 1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0), O_STL, 1, 0});
    tbl.push_back('{mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0), O_RUN, 1, 0});
    tbl.push_back('{mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), O_RUN, 1, 0});
    tbl.push_back('{mk(0, 2, 7, 1, 1, 1, 0, 0, 1, 1, 7, 0, 0, 0, 0), O_STL, 2, 0});
    tbl.push_back('{mk(0, 2, 7, 1, 1, 1, 0, 0, 0, 0, 0, 1, 7, 0, 0), O_STL, 3, 0});
    tbl.push_back('{mk(0, 2, 7, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), O_FLS, 3, 1});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), O_FLS, 3, 2});
    tbl.push_back('{mk(0, 3, 0, 1, 0, 1, 0, 1, 1, 0, 3, 0, 0, 0, 0), O_STL, 4, 2});
    tbl.push_back('{mk(0, 5, 0, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0), O_RUN, 4, 2});
    tbl.push_back('{mk(0, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0), O_RUN, 4, 2});
    tbl.push_back('{mk(0, 5, 0, 1, 0, 0, 1, 0, 1, 1, 5, 0, 0, 1, 1), O_ISS, 5, 2});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_FRZ, 6, 2});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_FRZ, 7, 2});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_FRZ, 8, 2});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_RUN, 8, 2});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_ISS, 9, 2});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), O_FLS, 9, 3});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_ISS, 10, 3});
    tbl.push_back('{mk(0, 5, 0, 1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 1, 1), O_STL, 11, 3});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_RUN, 11, 3});

    foreach (tbl[i]) begin
      apply(tbl[i].v);
      check($sformatf("row%0d/outputs", i), 32'(got_out), 32'(tbl[i].out));
      check_regs($sformatf("row%0d", i), tbl[i].stall, tbl[i].flush, 1'b0);
    end

    // Timeout: ready never comes; release happens on the 16th wait cycle.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    check("tmo/issue", 32'(got_out), 32'(O_ISS));
    for (int i = 0; i < TIMEOUT; i++) begin
      apply(nop(0));
      check($sformatf("tmo/freeze%0d", i), 32'(got_out), 32'(O_FRZ));
    end
    check("tmo/not_yet", 32'(mem_timeout_o), 32'd0);
    apply(nop(0));
    check("tmo/release", 32'(got_out), 32'(O_RUN));
    check_regs("tmo/after_release", CMAX, 0, 1'b1);
    for (int i = 0; i < 20; i++) apply(nop(0));
    check("tmo/run_after", 32'(got_out), 32'(O_RUN));
    check_regs("tmo/held", CMAX, 0, 1'b1);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("tmo/reset_out", 32'(got_out), 32'(O_RST));
    check_regs("tmo/reset", 0, 0, 1'b0);

    // Reset in the middle of a wait, then a long continuous load-use stall.
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    check("rw/issue", 32'(got_out), 32'(O_ISS));
    apply(nop(0));
    apply(nop(0));
    check("rw/freeze", 32'(got_out), 32'(O_FRZ));
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    check("rw/reset_out", 32'(got_out), 32'(O_RST));
    check_regs("rw/reset", 0, 0, 1'b0);
    apply(nop(0));
    check("rw/back_in_run", 32'(got_out), 32'(O_RUN));
    lu = mk(0, 9, 0, 1, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      apply(lu);
      check($sformatf("sat/out%0d", i), 32'(got_out), 32'(O_STL));
      check($sformatf("sat/stall%0d", i), 32'(stall_count_o), (i + 1 < CMAX) ? i + 1 : CMAX);
    end

    // Randomized phase against the reference model, varying memory latency.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int seg = 0; seg < 4; seg++) begin
      int bias;
      bias = (seg == 2) ? 0 : (seg == 1) ? 1 : (seg == 3) ? 6 : 3;
      for (int i = 0; i < 500; i++) begin
        apply(rnd(bias));
        check($sformatf("rnd%0d_%0d/outputs", seg, i), 32'(got_out), 32'(exp_out));
        check($sformatf("rnd%0d_%0d/regs", seg, i),
              32'({mem_timeout_o, stall_count_o, flush_count_o}),
              (32'(m_tmo) << (2 * CNT_W)) | (32'(m_stall) << CNT_W) | 32'(m_flush));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
